gmii_tx_mac: RTL



---
 rtl/gmii_tx_mac.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/gmii_tx_mac.sv
// Egress GMII transmit MAC: frames a byte stream with preamble/SFD, pads to
// minimum size, appends the CRC-32 FCS and enforces the inter-frame gap.
module gmii_tx_mac #(
  parameter int                    DATA_WIDTH      = 8,
  parameter int                    MIN_FRAME_BYTES = 60,
  parameter int                    IFG_BYTES       = 12,
  parameter logic [DATA_WIDTH-1:0] PREAMBLE_BYTE   = 8'h55,
  parameter logic [DATA_WIDTH-1:0] SFD_BYTE        = 8'hD5,
  parameter int                    CNT_WIDTH       = 16
) (
  input  logic                  switch_clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_data_i,
  input  logic                  in_valid_i,
  input  logic                  in_last_i,
  output logic                  in_ready_o,
  output logic [DATA_WIDTH-1:0] gmii_tx_data_o,
  output logic                  gmii_tx_en_o,
  output logic                  gmii_tx_er_o,
  output logic                  busy_o,
  output logic [CNT_WIDTH-1:0]  frames_sent_o,
  output logic [CNT_WIDTH-1:0]  underflow_cnt_o
);

  localparam logic [31:0]          CRC_POLY = 32'hEDB88320;
  localparam logic [31:0]          CRC_INIT = 32'hFFFFFFFF;
  localparam int                   PRE_BYTES = 7;
  localparam logic [7:0]           PRE_LAST = 8'(PRE_BYTES - 1);
  localparam logic [7:0]           IFG_LAST = 8'(IFG_BYTES - 1);
  localparam logic [6:0]           MIN_CNT  = 7'(MIN_FRAME_BYTES);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [3:0] {
    S_IDLE, S_PREAMBLE, S_SFD, S_DATA, S_PAD, S_FCS, S_ABORT, S_DRAIN, S_IFG
  } state_t;

  // The state names the byte the FSM produces for the next wire cycle; the
  // GMII registers then hold it, so the wire lags the decision by one cycle.
  state_t                  state_q, state_d;
  logic [7:0]              phase_q, phase_d;
  logic [6:0]              byte_cnt_q, byte_cnt_d;
  logic [31:0]             crc_q, crc_d;
  logic [DATA_WIDTH-1:0]   tx_data_q, tx_data_d;
  logic                    tx_en_q, tx_en_d;
  logic                    tx_er_q, tx_er_d;
  logic [CNT_WIDTH-1:0]    frames_q, frames_d;
  logic [CNT_WIDTH-1:0]    underflow_q, underflow_d;
  logic                    ready;
  logic [6:0]              next_cnt;

  function automatic logic [31:0] crc_step(input logic [31:0] crc,
                                           input logic [DATA_WIDTH-1:0] b);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (c[0] ^ b[i]) c = (c >> 1) ^ CRC_POLY;
      else             c = c >> 1;
    end
    return c;
  endfunction

  function automatic logic [6:0] cnt_sat_inc(input logic [6:0] c);
    return (c == 7'd127) ? c : c + 7'd1;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] fcs_byte(input logic [31:0] crc,
                                                     input logic [1:0] idx);
    logic [31:0] fcs;
    fcs = (~crc) >> {idx, 3'b000};
    return fcs[DATA_WIDTH-1:0];
  endfunction

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    byte_cnt_d  = byte_cnt_q;
    crc_d       = crc_q;
    tx_data_d   = '0;
    tx_en_d     = 1'b0;
    tx_er_d     = 1'b0;
    frames_d    = frames_q;
    underflow_d = underflow_q;
    ready       = 1'b0;
    next_cnt    = cnt_sat_inc(byte_cnt_q);

    case (state_q)
      S_IDLE: begin
        if (in_valid_i) begin
          state_d    = S_PREAMBLE;
          phase_d    = 8'd0;
          byte_cnt_d = 7'd0;
          crc_d      = CRC_INIT;
          tx_data_d  = PREAMBLE_BYTE;
          tx_en_d    = 1'b1;
        end
      end

      S_PREAMBLE: begin
        tx_en_d = 1'b1;
        if (phase_q == PRE_LAST) begin
          tx_data_d = SFD_BYTE;
          state_d   = S_SFD;
        end else begin
          tx_data_d = PREAMBLE_BYTE;
          phase_d   = phase_q + 8'd1;
        end
      end

      // SFD and DATA both pull the next byte; an empty stream here is an underflow.
      S_SFD, S_DATA: begin
        ready   = 1'b1;
        tx_en_d = 1'b1;
        if (in_valid_i) begin
          tx_data_d  = in_data_i;
          crc_d      = crc_step(crc_q, in_data_i);
          byte_cnt_d = next_cnt;
          phase_d    = 8'd0;
          if (in_last_i) state_d = (next_cnt < MIN_CNT) ? S_PAD : S_FCS;
          else           state_d = S_DATA;
        end else begin
          tx_er_d     = 1'b1;
          underflow_d = underflow_q + CNT_ONE;
          state_d     = S_ABORT;
        end
      end

      S_PAD: begin
        tx_en_d    = 1'b1;
        crc_d      = crc_step(crc_q, '0);
        byte_cnt_d = next_cnt;
        if (next_cnt >= MIN_CNT) begin
          state_d = S_FCS;
          phase_d = 8'd0;
        end
      end

      S_FCS: begin
        tx_en_d   = 1'b1;
        tx_data_d = fcs_byte(crc_q, phase_q[1:0]);
        if (phase_q[1:0] == 2'd3) begin
          frames_d = frames_q + CNT_ONE;
          state_d  = S_IFG;
          phase_d  = 8'd0;
        end else begin
          phase_d = phase_q + 8'd1;
        end
      end

      S_ABORT: state_d = S_DRAIN;

      S_DRAIN: begin
        ready = 1'b1;
        if (in_valid_i && in_last_i) begin
          state_d = S_IFG;
          phase_d = 8'd0;
        end
      end

      S_IFG: begin
        if (phase_q == IFG_LAST) state_d = S_IDLE;
        else                     phase_d = phase_q + 8'd1;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Register stage: FSM state, CRC accumulator and the GMII output flops.
  always_ff @(posedge switch_clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      phase_q     <= 8'd0;
      byte_cnt_q  <= 7'd0;
      crc_q       <= CRC_INIT;
      tx_data_q   <= '0;
      tx_en_q     <= 1'b0;
      tx_er_q     <= 1'b0;
      frames_q    <= '0;
      underflow_q <= '0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      byte_cnt_q  <= byte_cnt_d;
      crc_q       <= crc_d;
      tx_data_q   <= tx_data_d;
      tx_en_q     <= tx_en_d;
      tx_er_q     <= tx_er_d;
      frames_q    <= frames_d;
      underflow_q <= underflow_d;
    end
  end

  // Gate ready with rst so a byte is never consumed by an edge that resets us.
  assign in_ready_o      = ready & ~rst;
  assign gmii_tx_data_o  = tx_data_q;
  assign gmii_tx_en_o    = tx_en_q;
  assign gmii_tx_er_o    = tx_er_q;
  assign busy_o          = (state_q != S_IDLE);
  assign frames_sent_o   = frames_q;
  assign underflow_cnt_o = underflow_q;

endmodule
